matrix_index_sequencer: RTL and testbench
=========================================

# matrix_index_sequencer

Parametrised successor to the single modulo counter with terminal flag: a two-level (row/column) index generator that walks a runtime-sized matrix in row-major order. Runtime dimensions are bounded by parameters. The block has a start/busy/done control FSM and a valid/ready output handshake. It drives the operand-address side of the matrix-vector datapath and stalls cleanly under downstream back-pressure.

## Interface
- MAX_ROWS, 8, largest row count accepted at runtime (>=1)
- MAX_COLS, 8, largest column count accepted at runtime (>=1)
- IDX_R_BITS, max(1, ceil(log2(MAX_ROWS))), width of row_idx
- IDX_C_BITS, max(1, ceil(log2(MAX_COLS))), width of col_idx
- DIM_R_BITS, ceil(log2(MAX_ROWS+1)), width of rows_cfg (must hold MAX_ROWS)
- DIM_C_BITS, ceil(log2(MAX_COLS+1)), width of cols_cfg
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- start  in  1  request a new walk; sampled only in IDLE
- rows_cfg  in  DIM_R_BITS  row count, latched on accepted start
- cols_cfg  in  DIM_C_BITS  column count, latched on accepted start
- ready  in  1  downstream accepts current index this cycle
- abort  in  1  terminate walk; no done pulse
- valid  out  1  row_idx/col_idx hold a valid index
- row_idx  out  IDX_R_BITS  current row
- col_idx  out  IDX_C_BITS  current column
- row_last  out  1  valid && col_idx == cols-1
- last  out  1  valid && final element (rows-1, cols-1)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the final handshake
- cfg_err  out  1  one-cycle pulse when start is rejected

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE. All outputs 0 in reset and in IDLE; indices 0.
- IDLE + start:
  - If rows_cfg==0, cols_cfg==0, rows_cfg>MAX_ROWS or cols_cfg>MAX_COLS: pulse cfg_err, stay IDLE, latch nothing.
  - Otherwise latch rows/cols, clear indices, go to RUN.
- RUN: valid=1. A handshake occurs on valid && ready.
  - col < cols-1: col_idx+1.
  - col == cols-1 and row < rows-1: col_idx=0, row_idx+1.
  - Final element: go to DONE, clear indices.
- No handshake (ready=0): indices and flags hold unchanged.
- DONE: done=1, valid=0 for exactly one cycle, then IDLE.
- abort in RUN: go to IDLE next edge, indices cleared, no done.
  - abort coincident with the final handshake: abort wins, no done pulse.
  - abort in IDLE or DONE: ignored; DONE still completes.
- start outside IDLE: ignored, no cfg_err. start coincident with done (DONE state): ignored.
- Config changes after latch have no effect until the next accepted start.
- Arithmetic: compares against latched cfg minus 1 at DIM widths. Index increments wrap only via the explicit clear, never by overflow. MAX_ROWS/MAX_COLS at powers of two (idx full range) must work.

## Timing
- Accepted start at edge N: busy and valid high after edge N, so the first index is visible in cycle N+1.
- With ready held high: one index per cycle, rows*cols valid cycles. done is high in the cycle after the last handshake. busy falls one cycle after done.
- Total latency, start to done (ready=1): rows*cols+1 cycles after the start edge.
- cfg_err is high in the cycle following the rejecting start edge. busy stays 0.
- valid/row_last/last/busy/done are decoded from registered state only; there are no combinational paths from ready/start/abort to outputs.
- Asynchronous reset mid-walk: all outputs 0 immediately. The walk is lost and no done is produced.

## Test plan
- rows=2, cols=3, ready=1: indices (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) on 6 consecutive cycles. row_last on the 3rd and 6th, last on the 6th. done one cycle later; busy low the next cycle.
- Same config, ready toggled 1,0,0,1,...: each index held while ready=0. Exactly 6 handshakes, no skipped or repeated index. done only after the 6th handshake.
- rows=1, cols=1 and rows=MAX_ROWS, cols=MAX_COLS (8x8): the 1x1 walk gives valid+row_last+last in a single cycle, then done. The 8x8 walk gives 64 beats ending at (7,7).
- start with cols=0, then with rows=9 (MAX_ROWS=8): cfg_err pulses once each, busy stays 0, valid never rises.
- rows=3, cols=3 with abort at beat 4: valid drops next cycle, no done, back in IDLE. A new start works from (0,0). Abort on the final beat also gives no done.
- start pulsed during RUN with a different cfg, then reset asserted mid-walk: the extra start is ignored. Reset gives immediate all-zero outputs, and the block is idle after release.

Source files
------------

// File: rtl/matrix_index_sequencer.sv
// Row-major (row, col) index generator for a runtime-sized matrix.
// A start/busy/done FSM drives a valid/ready stream that holds its index under back-pressure.
module matrix_index_sequencer #(
  parameter int MAX_ROWS   = 8,
  parameter int MAX_COLS   = 8,
  parameter int IDX_R_BITS = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1,
  parameter int IDX_C_BITS = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1,
  parameter int DIM_R_BITS = $clog2(MAX_ROWS + 1),
  parameter int DIM_C_BITS = $clog2(MAX_COLS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIM_R_BITS-1:0] rows_cfg,
  input  logic [DIM_C_BITS-1:0] cols_cfg,
  input  logic                  ready,
  input  logic                  abort,
  output logic                  valid,
  output logic [IDX_R_BITS-1:0] row_idx,
  output logic [IDX_C_BITS-1:0] col_idx,
  output logic                  row_last,
  output logic                  last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [DIM_R_BITS-1:0] MAX_R = DIM_R_BITS'(MAX_ROWS);
  localparam logic [DIM_C_BITS-1:0] MAX_C = DIM_C_BITS'(MAX_COLS);

  state_t                  state;
  logic [IDX_R_BITS-1:0]   row_q;
  logic [IDX_C_BITS-1:0]   col_q;
  logic [DIM_R_BITS-1:0]   rows_m1;
  logic [DIM_C_BITS-1:0]   cols_m1;
  logic                    cfg_err_q;

  logic                    cfg_bad;
  logic                    col_at_end;
  logic                    row_at_end;

  assign cfg_bad = (rows_cfg == '0) || (cols_cfg == '0) ||
                   (rows_cfg > MAX_R) || (cols_cfg > MAX_C);

  // Index compares are done at the dimension width so a full-range index never overflows.
  assign col_at_end = (DIM_C_BITS'(col_q) == cols_m1);
  assign row_at_end = (DIM_R_BITS'(row_q) == rows_m1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      rows_m1   <= '0;
      cols_m1   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err_q <= 1'b1;
            end else begin
              rows_m1 <= rows_cfg - DIM_R_BITS'(1);
              cols_m1 <= cols_cfg - DIM_C_BITS'(1);
              row_q   <= '0;
              col_q   <= '0;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          // Abort outranks a coincident final handshake, so no done is produced.
          if (abort) begin
            row_q <= '0;
            col_q <= '0;
            state <= IDLE;
          end else if (ready) begin
            if (!col_at_end) begin
              col_q <= col_q + IDX_C_BITS'(1);
            end else if (!row_at_end) begin
              col_q <= '0;
              row_q <= row_q + IDX_R_BITS'(1);
            end else begin
              row_q <= '0;
              col_q <= '0;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign valid    = (state == RUN);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign row_idx  = row_q;
  assign col_idx  = col_q;
  assign row_last = valid && col_at_end;
  assign last     = row_last && row_at_end;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_matrix_index_sequencer.sv
// Directed bench for matrix_index_sequencer: expected beats are queued at start and
// compared as the sequencer presents them.
module tb_matrix_index_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] rows_cfg = '0;
  logic [3:0] cols_cfg = '0;
  logic       ready = 1'b0;
  logic       abort = 1'b0;
  logic       valid, row_last, last, busy, done, cfg_err;
  logic [2:0] row_idx, col_idx;

  typedef struct {
    int r;
    int c;
    int rl;
    int lst;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail = 0;

  matrix_index_sequencer #(.MAX_ROWS(8), .MAX_COLS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .rows_cfg(rows_cfg), .cols_cfg(cols_cfg),
    .ready(ready), .abort(abort), .valid(valid), .row_idx(row_idx), .col_idx(col_idx),
    .row_last(row_last), .last(last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"},    32'(valid),    0);
    chk({tag, "_busy"},     32'(busy),     0);
    chk({tag, "_done"},     32'(done),     0);
    chk({tag, "_row_last"}, 32'(row_last), 0);
    chk({tag, "_last"},     32'(last),     0);
    chk({tag, "_row_idx"},  32'(row_idx),  0);
    chk({tag, "_col_idx"},  32'(col_idx),  0);
    chk({tag, "_cfg_err"},  32'(cfg_err),  0);
  endtask

  task automatic push_walk(input int r, input int c);
    for (int i = 0; i < r * c; i++) begin
      exp_t e;
      e.r   = i / c;
      e.c   = i % c;
      e.rl  = (e.c == c - 1) ? 1 : 0;
      e.lst = (i == r * c - 1) ? 1 : 0;
      q.push_back(e);
    end
  endtask

  task automatic chk_beat(input string tag);
    chk({tag, "_valid"},    32'(valid),    1);
    chk({tag, "_busy"},     32'(busy),     1);
    chk({tag, "_done"},     32'(done),     0);
    chk({tag, "_row_idx"},  32'(row_idx),  q[0].r);
    chk({tag, "_col_idx"},  32'(col_idx),  q[0].c);
    chk({tag, "_row_last"}, 32'(row_last), q[0].rl);
    chk({tag, "_last"},     32'(last),     q[0].lst);
  endtask

  // toggle: ready pattern 1,0,0,1,0,0...; abort_at: beat (0-based) whose handshake carries abort
  task automatic walk(input int r, input int c, input bit toggle, input int abort_at);
    int beats = 0;
    int cyc = 0;
    bit rdy;
    bit ab;
    bit aborted = 1'b0;
    @(negedge clk);
    rows_cfg = 4'(r);
    cols_cfg = 4'(c);
    start = 1'b1;
    push_walk(r, c);
    @(negedge clk);
    start = 1'b0;
    while (q.size() > 0 && cyc < 500) begin
      chk_beat("beat");
      rdy = toggle ? (cyc % 3 == 0) : 1'b1;
      ab = rdy && (beats == abort_at);
      ready = rdy;
      abort = ab;
      if (rdy) begin
        void'(q.pop_front());
        beats++;
      end
      if (ab) begin
        aborted = 1'b1;
        q.delete();
      end
      @(negedge clk);
      cyc++;
    end
    ready = 1'b0;
    abort = 1'b0;
    chk("walk_within_budget", 32'(q.size()), 0);
    if (aborted) begin
      chk_idle("after_abort");
      @(negedge clk);
      chk("after_abort_no_done", 32'(done), 0);
    end else begin
      chk("handshakes", 32'(beats), 32'(r * c));
      if (!toggle) chk("latency_beats", 32'(cyc), 32'(r * c));
      chk("done_pulse", 32'(done),  1);
      chk("done_valid", 32'(valid), 0);
      chk("done_busy",  32'(busy),  1);
      @(negedge clk);
      chk_idle("post_done");
    end
  endtask

  task automatic reject(input int r, input int c);
    @(negedge clk);
    rows_cfg = 4'(r);
    cols_cfg = 4'(c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err), 1);
    chk("cfg_err_busy",  32'(busy),    0);
    chk("cfg_err_valid", 32'(valid),   0);
    @(negedge clk);
    chk_idle("cfg_err_after");
  endtask

  initial begin
    #3;
    chk_idle("in_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("after_reset");

    walk(2, 3, 1'b0, -1);
    walk(2, 3, 1'b1, -1);
    walk(1, 1, 1'b0, -1);
    walk(8, 8, 1'b0, -1);

    reject(2, 0);
    reject(9, 2);

    walk(3, 3, 1'b0, 3);
    walk(3, 3, 1'b0, -1);
    walk(2, 2, 1'b0, 3);

    // Start with a different cfg mid-walk must be ignored; then reset mid-walk.
    @(negedge clk);
    rows_cfg = 4'd3;
    cols_cfg = 4'd3;
    start = 1'b1;
    push_walk(3, 3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_beat("mid_walk");
      ready = 1'b1;
      start = (k == 1);
      if (k == 1) begin
        rows_cfg = 4'd1;
        cols_cfg = 4'd2;
      end
      void'(q.pop_front());
    end
    start = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_idle("async_reset");
    q.delete();
    ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("reset_release");

    walk(2, 2, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
